// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall vector from stall requests,
// registered flush pulse with redirect PC, and stall performance watchdog.
module pipe_ctrl #(
  parameter int                       NSTAGE        = 6,
  parameter int                       NREQ          = 2,
  parameter logic [NREQ*NSTAGE-1:0]   STALL_MAP     = {6'b000111, 6'b000011},
  parameter int                       FLUSH_LEN     = 1,
  parameter int                       STALL_TIMEOUT = 1024,
  parameter int                       CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   stallreq,
  input  logic              flush_req,
  input  logic [31:0]       flush_pc,
  input  logic              perf_clr,
  output logic [NSTAGE-1:0] stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic              stall_timeout
);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  localparam logic [3:0]       FLEN_M1 = 4'(FLUSH_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(STALL_TIMEOUT);

  // A mask is legal only when it is a run of ones starting at the fetch stage.
  function automatic bit map_ok();
    logic [NSTAGE-1:0] s;
    logic [NSTAGE-1:0] t;
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      s = STALL_MAP[i*NSTAGE +: NSTAGE];
      t = s + {{(NSTAGE-1){1'b0}}, 1'b1};
      if ((s & t) != {NSTAGE{1'b0}}) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  if (!map_ok()) begin : g_bad_map
    $error("pipe_ctrl: every STALL_MAP slice must be of the form 2^k-1");
  end
  if (FLUSH_LEN < 1 || FLUSH_LEN > 15) begin : g_bad_flen
    $error("pipe_ctrl: FLUSH_LEN must be in 1..15");
  end
  if (STALL_TIMEOUT < 1 || STALL_TIMEOUT > (2**CNT_W) - 1) begin : g_bad_to
    $error("pipe_ctrl: STALL_TIMEOUT out of range for CNT_W");
  end

  state_t             state_q, state_d;
  logic               flush_q, flush_d;
  logic [31:0]        new_pc_q, new_pc_d;
  logic [3:0]         flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]   run_len_q, run_len_d;
  logic               timeout_q, timeout_d;
  logic [NSTAGE-1:0]  stall_raw;
  logic               stall_any;

  // Merge the masks of all active requesters; gate to zero in reset or flush.
  always_comb begin
    stall_raw = {NSTAGE{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      stall_raw = stall_raw | (STALL_MAP[i*NSTAGE +: NSTAGE] & {NSTAGE{stallreq[i]}});
    end
    if (!rst || state_q == ST_FLUSH) begin
      stall = {NSTAGE{1'b0}};
    end else begin
      stall = stall_raw;
    end
    stall_any = |stall;
  end

  // RUN/FLUSH next state; a flush request in FLUSH restarts the window.
  always_comb begin
    state_d     = state_q;
    flush_d     = flush_q;
    new_pc_d    = new_pc_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (flush_req) begin
          state_d     = ST_FLUSH;
          flush_d     = 1'b1;
          new_pc_d    = flush_pc;
          flush_cnt_d = FLEN_M1;
        end else begin
          flush_d     = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (flush_req) begin
          flush_d     = 1'b1;
          new_pc_d    = flush_pc;
          flush_cnt_d = FLEN_M1;
        end else if (flush_cnt_q == 4'd0) begin
          state_d     = ST_RUN;
          flush_d     = 1'b0;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d     = ST_RUN;
        flush_d     = 1'b0;
        flush_cnt_d = 4'd0;
      end
    endcase
  end

  // Stall statistics: saturating total, run length and sticky watchdog.
  always_comb begin
    if (stall_any) begin
      if (run_len_q == TO_VAL) begin
        run_len_d = run_len_q;
      end else begin
        run_len_d = run_len_q + CNT_ONE;
      end
    end else begin
      run_len_d = {CNT_W{1'b0}};
    end

    if (perf_clr) begin
      stall_cycles_d = {CNT_W{1'b0}};
    end else if (stall_any && stall_cycles_q != CNT_MAX) begin
      stall_cycles_d = stall_cycles_q + CNT_ONE;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end

    if (perf_clr) begin
      timeout_d = 1'b0;
    end else if (stall_any && run_len_d == TO_VAL) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_RUN;
      flush_q        <= 1'b0;
      new_pc_q       <= 32'h0000_0000;
      flush_cnt_q    <= 4'd0;
      stall_cycles_q <= {CNT_W{1'b0}};
      run_len_q      <= {CNT_W{1'b0}};
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      flush_q        <= flush_d;
      new_pc_q       <= new_pc_d;
      flush_cnt_q    <= flush_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      run_len_q      <= run_len_d;
      timeout_q      <= timeout_d;
    end
  end

  assign flush         = flush_q;
  assign new_pc        = new_pc_q;
  assign stall_cycles  = stall_cycles_q;
  assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic checked
// against a cycle-count reference model of stall, flush and statistics.
module tb_pipe_ctrl;

  localparam int FLEN = 3;
  localparam int TOUT = 4;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic        clk;
  logic        rst;
  logic [1:0]  stallreq;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic        perf_clr;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [CW-1:0] stall_cycles;
  logic        stall_timeout;

  pipe_ctrl #(
    .NSTAGE(6), .NREQ(2), .STALL_MAP({6'b000111, 6'b000011}),
    .FLUSH_LEN(FLEN), .STALL_TIMEOUT(TOUT), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req),
    .flush_pc(flush_pc), .perf_clr(perf_clr), .stall(stall), .flush(flush),
    .new_pc(new_pc), .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: remaining flush cycles, redirect, counters.
  int          m_flush_left;
  logic [31:0] m_pc;
  int          m_cyc;
  int          m_run;
  bit          m_to;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [5:0] exp_stall(input logic [1:0] r);
    logic [5:0] v;
    v = 6'b0;
    if (m_flush_left > 0) return 6'b0;
    if (r[0]) v = v | 6'b000011;
    if (r[1]) v = v | 6'b000111;
    return v;
  endfunction

  task automatic model_reset();
    m_flush_left = 0;
    m_pc  = 32'h0;
    m_cyc = 0;
    m_run = 0;
    m_to  = 1'b0;
  endtask

  task automatic check_all();
    check_eq("stall", {26'b0, stall}, {26'b0, exp_stall(stallreq)});
    check_eq("flush", {31'b0, flush}, {31'b0, (m_flush_left > 0)});
    check_eq("new_pc", new_pc, m_pc);
    check_eq("stall_cycles", {28'b0, stall_cycles}, 32'(m_cyc));
    check_eq("stall_timeout", {31'b0, stall_timeout}, {31'b0, m_to});
  endtask

  task automatic drive(input logic [1:0] r, input logic fr, input logic [31:0] pc, input logic clr);
    stallreq  = r;
    flush_req = fr;
    flush_pc  = pc;
    perf_clr  = clr;
    #1;
    check_all();
  endtask

  task automatic tick();
    logic [5:0]  s;
    logic        fr;
    logic [31:0] pc;
    logic        clr;
    s   = exp_stall(stallreq);
    fr  = flush_req;
    pc  = flush_pc;
    clr = perf_clr;
    @(posedge clk);
    if (fr) begin
      m_flush_left = FLEN;
      m_pc = pc;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end
    if (s != 6'b0) m_run = (m_run < TOUT) ? m_run + 1 : TOUT;
    else m_run = 0;
    if (clr) begin
      m_cyc = 0;
      m_to  = 1'b0;
    end else begin
      if (s != 6'b0 && m_cyc < CMAX) m_cyc++;
      if (s != 6'b0 && m_run == TOUT) m_to = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b0;
    stallreq = 2'b11; flush_req = 1'b0; flush_pc = 32'h0; perf_clr = 1'b0;
    model_reset();
    #2;
    check_eq("rst_stall", {26'b0, stall}, 32'h0);
    check_eq("rst_flush", {31'b0, flush}, 32'h0);
    check_eq("rst_new_pc", new_pc, 32'h0);
    check_eq("rst_cycles", {28'b0, stall_cycles}, 32'h0);
    check_eq("rst_timeout", {31'b0, stall_timeout}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Stall mask decode, same cycle.
    drive(2'b10, 1'b0, 32'h0, 1'b0); check_eq("map_10", {26'b0, stall}, 32'h07); tick();
    drive(2'b01, 1'b0, 32'h0, 1'b0); check_eq("map_01", {26'b0, stall}, 32'h03); tick();
    drive(2'b11, 1'b0, 32'h0, 1'b0); check_eq("map_11", {26'b0, stall}, 32'h07); tick();
    drive(2'b00, 1'b0, 32'h0, 1'b0); check_eq("map_00", {26'b0, stall}, 32'h00); tick();

    // Single flush while stalled.
    drive(2'b11, 1'b1, 32'h0000_1000, 1'b0); check_eq("fl_req_stall", {26'b0, stall}, 32'h07); tick();
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 1'b0, 32'h0, 1'b0);
      check_eq("fl_on", {31'b0, flush}, 32'h1);
      check_eq("fl_pc", new_pc, 32'h0000_1000);
      check_eq("fl_stall0", {26'b0, stall}, 32'h0);
      tick();
    end
    drive(2'b11, 1'b0, 32'h0, 1'b0);
    check_eq("fl_off", {31'b0, flush}, 32'h0);
    check_eq("fl_stall_back", {26'b0, stall}, 32'h07);
    tick();

    // Back-to-back flush restarts the window.
    drive(2'b00, 1'b1, 32'h0000_1000, 1'b0); tick();
    drive(2'b00, 1'b0, 32'h0, 1'b0); tick();
    drive(2'b00, 1'b1, 32'h0000_2000, 1'b0); check_eq("fl2_c2", {31'b0, flush}, 32'h1); tick();
    for (int k = 0; k < 3; k++) begin
      drive(2'b00, 1'b0, 32'h0, 1'b0);
      check_eq("fl2_on", {31'b0, flush}, 32'h1);
      check_eq("fl2_pc", new_pc, 32'h0000_2000);
      tick();
    end
    drive(2'b00, 1'b0, 32'h0, 1'b0);
    check_eq("fl2_off", {31'b0, flush}, 32'h0);
    check_eq("fl2_pc_hold", new_pc, 32'h0000_2000);
    tick();

    // Watchdog: broken runs do not trip it, an unbroken run of 4 does.
    drive(2'b00, 1'b0, 32'h0, 1'b1); tick();
    for (int k = 0; k < 3; k++) begin drive(2'b01, 1'b0, 32'h0, 1'b0); tick(); end
    drive(2'b00, 1'b0, 32'h0, 1'b0); tick();
    for (int k = 0; k < 3; k++) begin drive(2'b10, 1'b0, 32'h0, 1'b0); tick(); end
    drive(2'b00, 1'b0, 32'h0, 1'b0);
    check_eq("wd_cycles6", {28'b0, stall_cycles}, 32'd6);
    check_eq("wd_not_yet", {31'b0, stall_timeout}, 32'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(2'b01, 1'b0, 32'h0, 1'b0);
      check_eq("wd_pre", {31'b0, stall_timeout}, 32'h0);
      tick();
    end
    drive(2'b00, 1'b0, 32'h0, 1'b0); check_eq("wd_set", {31'b0, stall_timeout}, 32'h1); tick();
    drive(2'b00, 1'b0, 32'h0, 1'b0); check_eq("wd_sticky", {31'b0, stall_timeout}, 32'h1); tick();

    // Saturation and clear priority.
    drive(2'b00, 1'b0, 32'h0, 1'b1); tick();
    for (int k = 0; k < 20; k++) begin drive(2'b11, 1'b0, 32'h0, 1'b0); tick(); end
    drive(2'b11, 1'b0, 32'h0, 1'b1); check_eq("sat15", {28'b0, stall_cycles}, 32'd15); tick();
    drive(2'b11, 1'b0, 32'h0, 1'b0);
    check_eq("clr_cycles", {28'b0, stall_cycles}, 32'h0);
    check_eq("clr_timeout", {31'b0, stall_timeout}, 32'h0);
    tick();

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      drive(2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), $urandom,
            ($urandom_range(0, 19) == 0));
      tick();
    end

    // Asynchronous reset in the middle of a flush.
    drive(2'b11, 1'b1, 32'h0000_3000, 1'b0); tick();
    drive(2'b11, 1'b0, 32'h0, 1'b0); check_eq("ar_in_flush", {31'b0, flush}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_eq("ar_flush", {31'b0, flush}, 32'h0);
    check_eq("ar_stall", {26'b0, stall}, 32'h0);
    check_eq("ar_cycles", {28'b0, stall_cycles}, 32'h0);
    check_eq("ar_timeout", {31'b0, stall_timeout}, 32'h0);
    check_eq("ar_new_pc", new_pc, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(2'b11, 1'b0, 32'h0, 1'b0);
    check_eq("ar_release_stall", {26'b0, stall}, 32'h07);
    check_eq("ar_release_flush", {31'b0, flush}, 32'h0);
    tick();
    drive(2'b01, 1'b0, 32'h0, 1'b0); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter NSTAGE, default 6: number of pipeline stages; bit 0 of every stage vector is the fetch/PC stage.
REQ-002 Parameter NREQ, default 2: number of stall-request sources.
REQ-003 Parameter STALL_MAP, default {6'b000111, 6'b000011}: NREQ*NSTAGE bits; slice [i*NSTAGE +: NSTAGE] is the stall mask of source i.
REQ-004 Parameter FLUSH_LEN, default 1: cycles flush stays asserted per flush event, range 1..15.
REQ-005 Parameter STALL_TIMEOUT, default 1024: consecutive stalled cycles that raise the watchdog, range 1..2^CNT_W-1.
REQ-006 Parameter CNT_W, default 16: width of the performance and run-length counters.
REQ-007 clk  input  1  single clock; all state updates on the rising edge.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 stallreq  input  NREQ  per-source stall request, active high, level-sensitive.
REQ-010 flush_req  input  1  single-cycle request to flush the pipeline (exception or redirect).
REQ-011 flush_pc  input  32  redirect target, sampled with flush_req.
REQ-012 perf_clr  input  1  synchronous clear of stall_cycles and stall_timeout.
REQ-013 stall  output  NSTAGE  per-stage hold; 1 = stage holds its state.
REQ-014 flush  output  1  registered flush pulse to all stages.
REQ-015 new_pc  output  32  registered redirect target, valid while flush=1.
REQ-016 stall_cycles  output  CNT_W  saturating count of cycles with stall != 0.
REQ-017 stall_timeout  output  1  sticky watchdog flag.

Function
REQ-018 Each STALL_MAP slice SHALL be contiguous from bit 0 (2^k-1 form); an elaboration-time check SHALL reject other values.
REQ-019 Two-state FSM, states RUN and FLUSH; reset state is RUN.
REQ-020 In RUN: stall = bitwise OR of the STALL_MAP slices of all asserted stallreq bits; combinational, same-cycle as stallreq.
REQ-021 In FLUSH: stall forced to all zeros regardless of stallreq; flush has priority over stall.
REQ-022 flush_req=1 in RUN: next edge enters FLUSH, flush<=1, new_pc<=flush_pc, flush counter loaded with FLUSH_LEN-1.
REQ-023 In FLUSH: counter decrements each cycle; at 0 with no new flush_req, next edge returns to RUN with flush<=0; flush is asserted for exactly FLUSH_LEN cycles.
REQ-024 flush_req=1 while in FLUSH: new_pc<=flush_pc, counter reloaded to FLUSH_LEN-1, state stays FLUSH (flush window restarts, no gap).
REQ-025 flush_req together with stallreq in RUN: stall follows stallreq in that cycle; flush takes effect next cycle per REQ-021.
REQ-026 new_pc holds its last value when flush=0.
REQ-027 stall_cycles increments by 1 on each edge where stall != 0 and saturates at 2^CNT_W-1 (no wrap).
REQ-028 Run-length counter increments while stall != 0, clears to 0 on any cycle with stall == 0, and saturates at STALL_TIMEOUT.
REQ-029 When the run-length counter reaches STALL_TIMEOUT, stall_timeout<=1 on that edge and stays 1 until perf_clr or reset.
REQ-030 perf_clr=1 clears stall_cycles and stall_timeout on the next edge and takes priority over increment/set in the same cycle; the run-length counter is not cleared.
REQ-031 stallreq bits not covered by NREQ do not exist; all-zero stallreq gives stall=0.

Reset
REQ-032 rst=0 immediately, without a clock: state=RUN, flush=0, new_pc=32'h0, flush counter=0, stall_cycles=0, run-length=0, stall_timeout=0.
REQ-033 While rst=0, stall SHALL be all zeros regardless of stallreq.
REQ-034 Reset asserted mid-FLUSH aborts the flush; after release the FSM is in RUN with flush=0.

Verification
REQ-035 Defaults; stallreq=2'b10 -> stall=6'b000111 same cycle; stallreq=2'b01 -> 6'b000011; 2'b11 -> 6'b000111; 2'b00 -> 0.
REQ-036 FLUSH_LEN=3; flush_req pulse with flush_pc=32'h0000_1000 while stallreq=2'b11 -> flush=1 and new_pc=32'h1000 for exactly 3 cycles, stall=0 during them, stall=6'b000111 again after.
REQ-037 FLUSH_LEN=3; second flush_req (pc 32'h2000) in 2nd flush cycle -> flush stays 1 for 3 more cycles, new_pc=32'h2000, no deassert gap.
REQ-038 STALL_TIMEOUT=4; stallreq held 3 cycles, 1 idle, 3 cycles -> stall_timeout stays 0, stall_cycles=6; then 4 consecutive -> stall_timeout=1 and stays 1 after stallreq drops.
REQ-039 CNT_W=4; 20 stalled cycles -> stall_cycles saturates at 15; perf_clr with stall active -> stall_cycles=0 and stall_timeout=0 next cycle.
REQ-040 rst pulled low asynchronously mid-flush with stallreq=2'b11 -> flush=0, stall=0, counters 0 before the next edge; release -> RUN, stall follows stallreq.
